// File: rtl/ysyx_220066_ifu_if.sv
// rtl/ysyx_220066_ifu_if.sv - fetch unit bundle: redirect, imem request/response, decode channel
interface ysyx_220066_ifu_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;

  // Fetch unit side
  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output inst_valid, inst, inst_pc, inst_fault,
    input  inst_ready
  );

  // Memory / execute / decode side
  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  inst_valid, inst, inst_pc, inst_fault,
    output inst_ready
  );
endinterface

// File: rtl/ysyx_220066_ifu.sv
// rtl/ysyx_220066_ifu.sv - instruction fetch unit; optional misaligned-redirect fault via YSYX_220066_IFU_ALIGN_CHECK_EN
module ysyx_220066_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_220066_ifu_if.master       bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        misal_q, misal_d;    // a killed request is followed by a misalignment fault
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        fault_q, fault_d;
  logic        req_valid_q, inst_valid_q;

  logic [63:0] redir_tgt;
  logic        redir_bad;
  logic        req_fire;

`ifdef YSYX_220066_IFU_ALIGN_CHECK_EN
  assign redir_tgt = bus.redirect_pc;
  assign redir_bad = bus.redirect_pc[1:0] != 2'b00;
`else
  logic unused_redir_lo;
  assign unused_redir_lo = ^bus.redirect_pc[1:0];
  assign redir_tgt = {bus.redirect_pc[63:2], 2'b00};
  assign redir_bad = 1'b0;
`endif

  assign req_fire = req_valid_q && bus.imem_req_ready;

  // Next-state: PC selection, kill tracking and instruction capture
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    misal_d   = misal_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    fault_d   = fault_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.redirect_valid) begin
          pc_d = redir_tgt;
          if (req_fire) begin
            // old request already accepted: drop its response in WAIT
            kill_d  = 1'b1;
            misal_d = redir_bad;
            state_d = WAIT;
          end else if (redir_bad) begin
            inst_d    = NOP_INST;
            inst_pc_d = redir_tgt;
            fault_d   = 1'b1;
            state_d   = OUT;
          end
        end else if (req_fire) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          pc_d    = redir_tgt;
          misal_d = redir_bad;
          if (bus.imem_rsp_valid) begin
            kill_d = 1'b0;
            if (redir_bad) begin
              inst_d    = NOP_INST;
              inst_pc_d = redir_tgt;
              fault_d   = 1'b1;
              state_d   = OUT;
            end else begin
              state_d = REQ;
            end
          end else begin
            kill_d = 1'b1;
          end
        end else if (bus.imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            misal_d = 1'b0;
            if (misal_q) begin
              inst_d    = NOP_INST;
              inst_pc_d = pc_q;
              fault_d   = 1'b1;
              state_d   = OUT;
            end else begin
              state_d = REQ;
            end
          end else begin
            inst_d    = bus.imem_rsp_data;
            inst_pc_d = pc_q;
            fault_d   = bus.imem_rsp_err;
            state_d   = OUT;
          end
        end
      end
      OUT: begin
        if (bus.redirect_valid) begin
          pc_d = redir_tgt;
          if (redir_bad) begin
            inst_d    = NOP_INST;
            inst_pc_d = redir_tgt;
            fault_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + 64'd4;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with registered handshake valids
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      misal_q      <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 64'h0;
      fault_q      <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      misal_q      <= misal_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      fault_q      <= fault_d;
      req_valid_q  <= (state_d == REQ);
      inst_valid_q <= (state_d == OUT);
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.inst_fault     = fault_q;

endmodule

// File: doc/ysyx_220066_ifu.md
Name: ysyx_220066_ifu

Overview:
- Instruction fetch unit. It is the consumer of the next-PC value computed in execute.
- Holds the architectural PC and issues one instruction-memory request at a time over a valid/ready channel.
- Presents the fetched instruction to decode over a valid/ready channel.
- Advances the PC by 4 on every decode handshake. A redirect from execute (the computed next PC, used for jumps and taken branches) overrides this.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset; first fetch address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  execute supplies a non-sequential next PC this cycle.
- redirect_pc  in  64  redirect target (next PC from execute).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  64  fetch address; equals the current PC.
- imem_rsp_valid  in  1  response valid; memory never stalls the response, and no ready signal is provided.
- imem_rsp_data  in  32  fetched instruction word.
- imem_rsp_err  in  1  access fault on this response.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts the instruction.
- inst  out  32  instruction word.
- inst_pc  out  64  PC of the instruction.
- inst_fault  out  1  instruction carries a fetch fault.

Behaviour:
- States: IDLE, REQ, WAIT, OUT.
- At most one memory request is outstanding.
- Reset, asynchronous:
  - State is IDLE; pc = RESET_PC; kill = 0.
  - inst, inst_pc and inst_fault are 0.
  - imem_req_valid and inst_valid are 0.
- IDLE -> REQ unconditionally on the first edge after rst deasserts.
- REQ:
  - imem_req_valid = 1 and imem_req_addr = pc.
  - req handshake (valid & ready) -> WAIT.
  - Redirect with no handshake: pc <= redirect_pc, stay in REQ. The address changes only on redirect.
  - Redirect in the same cycle as the handshake: the old request is in flight. kill <= 1, pc <= redirect_pc, -> WAIT.
- WAIT:
  - No request is issued.
  - On imem_rsp_valid with kill = 1: discard the response, kill <= 0, -> REQ.
  - On imem_rsp_valid with kill = 0: inst <= imem_rsp_data, inst_pc <= pc, inst_fault <= imem_rsp_err, -> OUT.
  - Redirect during WAIT: pc <= redirect_pc, kill <= 1. If rsp_valid arrives in the same cycle, that response is discarded, kill stays 0, -> REQ.
- OUT:
  - inst_valid = 1. inst, inst_pc and inst_fault are held stable until the handshake.
  - inst_ready -> pc <= pc + 4, -> REQ.
  - Redirect has priority over inst_ready in the same cycle: pc <= redirect_pc, -> REQ, and the instruction is dropped (no handshake counts).
- pc + 4 is a 64-bit add; it wraps at 2^64 with no flag.
- A fault response is delivered like a normal one. Fetch continues at pc + 4 unless redirected; trap handling is downstream.
- Total latency: request is visible the cycle after entering REQ is… more precisely: minimum 3 cycles from entering REQ to inst_valid (REQ, WAIT with zero-latency memory, OUT).

Optional Feature:
- Macro: YSYX_220066_IFU_ALIGN_CHECK_EN.
- Enabled:
  - A redirect_pc with bits [1:0] != 0 issues no memory request.
  - pc <= redirect_pc; the next state is OUT with inst = 32'h0000_0013, inst_pc = redirect_pc, inst_fault = 1.
  - If the redirect arrives in WAIT, kill is still set and the pending response is dropped before OUT is entered.
- Disabled: redirect_pc[1:0] is forced to 2'b00 before loading pc; no misalignment fault is generated.

Test Plan:
- Reset release with ready tied high and 1-cycle responses -> first imem_req_addr = 0x80000000; decode sees inst_pc 0x80000000, 0x80000004, 0x80000008 in order.
- inst_ready held low 5 cycles in OUT -> inst and inst_pc stable; no new imem request; after ready, next addr = inst_pc + 4.
- Redirect to 0x80001000 in WAIT, response arrives 2 cycles later with 0xDEADBEEF -> that word is never presented; next request addr = 0x80001000.
- Redirect to 0x80002000 in OUT, same cycle as inst_ready -> instruction dropped; next request addr = 0x80002000, not pc + 4.
- Response with imem_rsp_err = 1 at pc 0x80000010 -> inst_fault = 1, inst_pc = 0x80000010; next fetch 0x80000014.
- Enabled macro, redirect to 0x80000102 -> no request; inst_valid with inst = 0x00000013, inst_fault = 1, inst_pc = 0x80000102. Disabled macro -> request addr = 0x80000100.
- Assert rst mid-WAIT -> outputs clear immediately; after release the first addr = 0x80000000 and the stale response is ignored.
